pipe_reg_n: RTL and testbench
=============================

# pipe_reg_n

Parametrised inter-stage pipeline register for the five-stage CPU. It replaces the fixed-width EX/MEM and MEM/WB latches with a single block that has configurable payload width, lane count and depth. Stall (hold) and flush (bubble) are separate controls, and every entry carries a valid bit. The block also reports occupancy and keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- DATA_W, 32, width of one data lane
- NUM_DATA, 2, number of data lanes (ALU result, memory data, ...)
- CTRL_W, 2, control bits carried (bit0 = RegWrite, bit1 = MemtoReg by convention)
- ADDR_W, 5, destination register address width
- DEPTH, 1, number of register stages (≥1)
- CNT_W, 16, bubble counter width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous, active-high reset
- stall_i  in  1  hold every stage unchanged
- flush_i  in  1  clear every stage to a bubble
- valid_i  in  1  incoming entry is real
- ctrl_i  in  CTRL_W  incoming control bits
- data_i  in  NUM_DATA*DATA_W  lanes packed, lane k at [k*DATA_W +: DATA_W]
- rdaddr_i  in  ADDR_W  destination register
- clr_cnt_i  in  1  clear bubble counter
- valid_o  out  1  last stage valid
- ctrl_o  out  CTRL_W  last stage control
- data_o  out  NUM_DATA*DATA_W  last stage data
- rdaddr_o  out  ADDR_W  last stage destination
- occ_o  out  $clog2(DEPTH+1)  number of valid stages
- bubble_cnt_o  out  CNT_W  saturating count of bubble output cycles

## Operation
- Each stage s holds {valid, ctrl, data, rdaddr}. Stage 0 loads from the inputs. Stage s loads from stage s-1. Outputs come from stage DEPTH-1.
- Priority per edge: rst_i > flush_i > stall_i > advance.
- Reset: every stage field is 0, occ_o=0, bubble_cnt_o=0.
- flush_i=1: every stage field is 0 next cycle, regardless of stall_i. occ_o becomes 0.
- stall_i=1 with flush_i=0: all stages keep their contents, and inputs are ignored. occ_o is unchanged.
- Advance: all stages shift by one.
  - If valid_i=0, stage 0 loads all-zero (ctrl, data and rdaddr zeroed), not the raw inputs.
  - A bubble therefore never carries a nonzero RegWrite.
- Invariant: for every stage, valid=0 implies ctrl=0, data=0 and rdaddr=0.
- occ_o is a registered counter, not a popcount:
  - On advance, add valid_i and subtract the valid bit of stage DEPTH-1.
  - It must equal the popcount of the stage valid bits at all times. Verification checks this with an assertion.
- bubble_cnt_o:
  - Increments by 1 on each edge where valid_o=0 and rst_i=0.
  - Saturates at 2^CNT_W-1.
  - clr_cnt_i=1 sets it to 0 at the next edge and takes priority over increment.
  - Independent of stall_i and flush_i.

## Timing
- Latency: DEPTH cycles from input to valid_o when stall_i=0 throughout. Each stall cycle adds one.
- Throughput: one entry per cycle when not stalled.
- All outputs are registered. There is no combinational path from any input to any output.
- flush_i and stall_i asserted together act as flush. The cycle after, stall_i alone holds the zeroed state.
- Reset mid-stream: all in-flight entries are lost. Outputs are zero from the first edge with rst_i=1.
- Wrap: occ_o never exceeds DEPTH; the counter cannot overflow by construction.
- Saturation: at bubble_cnt_o=2^CNT_W-1 a further bubble leaves the value unchanged.

## Structure
- Shared package cpu_pipe_pkg holds:
  - ctrl bit index constants CTRL_REGWRITE=0 and CTRL_MEMTOREG=1
  - DATA_W and ADDR_W defaults
  - a packed stage-entry typedef built from the parameters
- Natural sub-module: pipe_reg_slot, one stage with load/hold/clear and the zero-on-invalid rule. Instantiate it DEPTH times in a generate loop.
- The occupancy and bubble counters live in the top level.

## Test plan
- Reset: rst_i=1 for 2 cycles with inputs nonzero -> every output 0, occ_o=0, bubble_cnt_o=0.
- Pass-through, DEPTH=3, NUM_DATA=2:
  - Stimulus: valid_i=1, ctrl_i=2'b01, data_i={32'hDEAD_BEEF, 32'h0000_1234}, rdaddr_i=5'd7, for one cycle.
  - Response: the same values on the outputs exactly 3 cycles later, then valid_o=0 with all fields 0.
  - occ_o goes 1,1,1,0.
- Stall vs flush:
  - Stream entries A, B, C. Assert stall_i for 2 cycles: outputs hold and occ_o holds.
  - Then assert flush_i with stall_i=1: next cycle all outputs 0 and occ_o=0.
  - Deassert both: only entries issued after the flush appear.
- Bubble gating: valid_i=0 with ctrl_i=2'b11, data_i=all-ones, rdaddr_i=31 -> that slot emerges with ctrl_o=0, data_o=0, rdaddr_o=0, valid_o=0.
- Bubble counter:
  - With CNT_W=3, hold valid_i=0 for 10 cycles after reset -> bubble_cnt_o saturates at 7.
  - clr_cnt_i pulse -> 0, then it resumes counting.
- Random: 10k cycles of random valid_i, stall_i, flush_i and rst_i.
  - Scoreboard against a reference queue.
  - Assert occ_o equals the popcount of the stage valid bits, and that the valid=0 implies zero-fields invariant holds.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers: control bit
// positions, default field widths and the default stage-entry layout.
package cpu_pipe_pkg;

  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_DATA = 2;
  localparam int DEF_CTRL_W   = 2;

  // Entry layout for the default EX/MEM and MEM/WB configuration.
  typedef struct packed {
    logic [DEF_CTRL_W-1:0]              ctrl;
    logic [DEF_NUM_DATA*DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0]              rdaddr;
  } stage_entry_t;

endpackage

// File: rtl/pipe_reg_slot.sv
// One pipeline register stage: clear, hold or load, with the payload forced
// to zero whenever the incoming entry is not valid.
module pipe_reg_slot
  import cpu_pipe_pkg::*;
#(
  parameter int PAY_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             hold_i,
  input  logic             valid_i,
  input  logic [PAY_W-1:0] payload_i,
  output logic             valid_o,
  output logic [PAY_W-1:0] payload_o
);

  logic             valid_q, valid_d;
  logic [PAY_W-1:0] payload_q, payload_d;

  // Clear beats hold, so a flush during a stall still produces a bubble.
  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (clear_i) begin
      valid_d   = 1'b0;
      payload_d = '0;
    end else if (!hold_i) begin
      valid_d   = valid_i;
      payload_d = valid_i ? payload_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign valid_o   = valid_q;
  assign payload_o = payload_q;

endmodule

// File: rtl/pipe_reg_n.sv
// Parametrised multi-stage pipeline register with stall, flush, per-entry
// valid, a registered occupancy counter and a saturating bubble counter.
module pipe_reg_n
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_DATA = DEF_NUM_DATA,
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 1,
  parameter int CNT_W    = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       stall_i,
  input  logic                       flush_i,
  input  logic                       valid_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  input  logic [NUM_DATA*DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0]          rdaddr_i,
  input  logic                       clr_cnt_i,
  output logic                       valid_o,
  output logic [CTRL_W-1:0]          ctrl_o,
  output logic [NUM_DATA*DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0]          rdaddr_o,
  output logic [$clog2(DEPTH+1)-1:0] occ_o,
  output logic [CNT_W-1:0]           bubble_cnt_o
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [CTRL_W-1:0]          ctrl;
    logic [NUM_DATA*DATA_W-1:0] data;
    logic [ADDR_W-1:0]          rdaddr;
  } entry_t;

  localparam int PAY_W = $bits(entry_t);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  entry_t           inEntry;
  entry_t           outEntry;
  logic [DEPTH-1:0] stageValid;
  logic [PAY_W-1:0] stagePay [DEPTH];

  assign inEntry = {ctrl_i, data_i, rdaddr_i};

  for (genvar s = 0; s < DEPTH; s++) begin : g_slot
    logic             srcValid;
    logic [PAY_W-1:0] srcPay;
    if (s == 0) begin : g_head
      assign srcValid = valid_i;
      assign srcPay   = inEntry;
    end else begin : g_tail
      assign srcValid = stageValid[s-1];
      assign srcPay   = stagePay[s-1];
    end

    pipe_reg_slot #(.PAY_W(PAY_W)) u_slot (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (flush_i),
      .hold_i    (stall_i),
      .valid_i   (srcValid),
      .payload_i (srcPay),
      .valid_o   (stageValid[s]),
      .payload_o (stagePay[s])
    );

    assert property (@(posedge clk_i) !stageValid[s] |-> (stagePay[s] == '0));
  end

  assign outEntry = stagePay[DEPTH-1];
  assign valid_o  = stageValid[DEPTH-1];
  assign ctrl_o   = outEntry.ctrl;
  assign data_o   = outEntry.data;
  assign rdaddr_o = outEntry.rdaddr;

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // Occupancy tracks entries in and out rather than counting valid bits.
  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (!stall_i) begin
      occ_d = occ_q + OCC_W'(valid_i) - OCC_W'(stageValid[DEPTH-1]);
    end
  end

  always_comb begin
    bubble_d = bubble_q;
    if (clr_cnt_i) begin
      bubble_d = '0;
    end else if (!stageValid[DEPTH-1] && (bubble_q != CNT_MAX)) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q    <= '0;
      bubble_q <= '0;
    end else begin
      occ_q    <= occ_d;
      bubble_q <= bubble_d;
    end
  end

  assign occ_o        = occ_q;
  assign bubble_cnt_o = bubble_q;

  assert property (@(posedge clk_i) disable iff (rst_i)
                   int'(occ_q) == $countones(stageValid));
  assert property (@(posedge clk_i)
                   !valid_o |-> (ctrl_o[CTRL_REGWRITE] == 1'b0 && ctrl_o[CTRL_MEMTOREG] == 1'b0));

endmodule

// File: tb/tb_pipe_reg_n.sv
// Randomised and directed checks of pipe_reg_n (DEPTH=3, CNT_W=3) against an
// array-of-entries reference model.
module tb_pipe_reg_n;

  localparam int DEPTH = 3;
  localparam int CNT_W = 3;
  localparam int BUB_MAX = (1 << CNT_W) - 1;

  logic        clk;
  logic        rst, stall, flush, vld, clr;
  logic [1:0]  ctrl;
  logic [63:0] data;
  logic [4:0]  rdaddr;
  logic        validO;
  logic [1:0]  ctrlO;
  logic [63:0] dataO;
  logic [4:0]  rdaddrO;
  logic [1:0]  occO;
  logic [2:0]  bubO;

  int checks;
  int failures;

  typedef struct packed {
    logic        v;
    logic [1:0]  c;
    logic [63:0] d;
    logic [4:0]  a;
  } ment_t;

  ment_t mdl [DEPTH];
  int    mBub;

  pipe_reg_n #(
    .DATA_W(32), .NUM_DATA(2), .CTRL_W(2), .ADDR_W(5), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .flush_i      (flush),
    .valid_i      (vld),
    .ctrl_i       (ctrl),
    .data_i       (data),
    .rdaddr_i     (rdaddr),
    .clr_cnt_i    (clr),
    .valid_o      (validO),
    .ctrl_o       (ctrlO),
    .data_o       (dataO),
    .rdaddr_o     (rdaddrO),
    .occ_o        (occO),
    .bubble_cnt_o (bubO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one edge of the pipeline expressed as list operations.
  task automatic modelEdge();
    ment_t incoming;
    int    occ;
    if (rst) mBub = 0;
    else if (clr) mBub = 0;
    else if (!mdl[DEPTH-1].v && mBub < BUB_MAX) mBub++;

    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    end else if (!stall) begin
      incoming = vld ? ment_t'{1'b1, ctrl, data, rdaddr} : '0;
      for (int i = DEPTH - 1; i > 0; i--) mdl[i] = mdl[i-1];
      mdl[0] = incoming;
    end
    occ = 0;
    foreach (mdl[i]) occ += int'(mdl[i].v);
    #1;
    checkOutput("valid",  64'(validO),  64'(mdl[DEPTH-1].v));
    checkOutput("ctrl",   64'(ctrlO),   64'(mdl[DEPTH-1].c));
    checkOutput("data",   dataO,        mdl[DEPTH-1].d);
    checkOutput("rdaddr", 64'(rdaddrO), 64'(mdl[DEPTH-1].a));
    checkOutput("occ",    64'(occO),    64'(occ));
    checkOutput("bubble", 64'(bubO),    64'(mBub));
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic s, input logic v,
                               input logic [1:0] c, input logic [63:0] d,
                               input logic [4:0] a, input logic cl);
    rst = r; flush = f; stall = s; vld = v; ctrl = c; data = d; rdaddr = a; clr = cl;
    @(posedge clk);
    modelEdge();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 2'b00, 64'h0, 5'd0, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    mBub = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rst = 1; flush = 0; stall = 0; vld = 1; ctrl = 2'b11; data = '1; rdaddr = 5'd31; clr = 0;

    // Reset with nonzero inputs
    applyStimulus(1, 0, 0, 1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 0);
    applyStimulus(1, 0, 0, 1, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 0);
    checkOutput("rst_valid", 64'(validO), 64'd0);
    checkOutput("rst_data",  dataO,       64'd0);
    checkOutput("rst_occ",   64'(occO),   64'd0);
    checkOutput("rst_bub",   64'(bubO),   64'd0);

    // Pass-through: visible exactly DEPTH edges after issue
    applyStimulus(0, 0, 0, 1, 2'b01, {32'hDEAD_BEEF, 32'h0000_1234}, 5'd7, 0);
    checkOutput("pt_occ1", 64'(occO), 64'd1);
    checkOutput("pt_v1",   64'(validO), 64'd0);
    idle(1);
    checkOutput("pt_occ2", 64'(occO), 64'd1);
    idle(1);
    checkOutput("pt_occ3",  64'(occO),    64'd1);
    checkOutput("pt_valid", 64'(validO),  64'd1);
    checkOutput("pt_ctrl",  64'(ctrlO),   64'd1);
    checkOutput("pt_data",  dataO,        64'hDEAD_BEEF_0000_1234);
    checkOutput("pt_addr",  64'(rdaddrO), 64'd7);
    idle(1);
    checkOutput("pt_occ4",  64'(occO),   64'd0);
    checkOutput("pt_after", 64'(validO), 64'd0);
    checkOutput("pt_dzero", dataO,       64'd0);

    // Stall then flush-with-stall
    applyStimulus(0, 0, 0, 1, 2'b01, 64'hAAAA_0000_0000_000A, 5'd1, 0);
    applyStimulus(0, 0, 0, 1, 2'b10, 64'hBBBB_0000_0000_000B, 5'd2, 0);
    applyStimulus(0, 0, 0, 1, 2'b11, 64'hCCCC_0000_0000_000C, 5'd3, 0);
    applyStimulus(0, 0, 1, 1, 2'b11, 64'h1, 5'd9, 0);
    applyStimulus(0, 0, 1, 1, 2'b11, 64'h2, 5'd9, 0);
    checkOutput("stall_data", dataO,     64'hAAAA_0000_0000_000A);
    checkOutput("stall_occ",  64'(occO), 64'd3);
    applyStimulus(0, 1, 1, 1, 2'b11, 64'h3, 5'd9, 0);
    checkOutput("flush_valid", 64'(validO), 64'd0);
    checkOutput("flush_occ",   64'(occO),   64'd0);
    applyStimulus(0, 0, 1, 1, 2'b11, 64'h4, 5'd9, 0);
    checkOutput("hold_zero", 64'(occO), 64'd0);
    applyStimulus(0, 0, 0, 1, 2'b01, 64'hDDDD_0000_0000_000D, 5'd4, 0);
    idle(2);
    checkOutput("post_flush", dataO, 64'hDDDD_0000_0000_000D);
    idle(1);

    // Bubble gating: junk on an invalid entry must not survive
    applyStimulus(0, 0, 0, 0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 0);
    idle(2);
    checkOutput("gate_ctrl", 64'(ctrlO),   64'd0);
    checkOutput("gate_data", dataO,        64'd0);
    checkOutput("gate_addr", 64'(rdaddrO), 64'd0);

    // Bubble counter saturation and clear
    applyStimulus(1, 0, 0, 0, 2'b00, 64'h0, 5'd0, 0);
    idle(10);
    checkOutput("bub_sat", 64'(bubO), 64'd7);
    applyStimulus(0, 0, 0, 0, 2'b00, 64'h0, 5'd0, 1);
    checkOutput("bub_clr", 64'(bubO), 64'd0);
    idle(1);
    checkOutput("bub_resume", 64'(bubO), 64'd1);

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
                    ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), {$urandom, $urandom},
                    5'($urandom_range(0, 31)), ($urandom_range(0, 31) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
